// File: rtl/shiftreg_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : shiftreg_load_ctrl
// Purpose : Arbitrates requesters onto one parallel-load shift register and
//           enforces the serial shift window between loads.
//           Define SHREG_CTRL_RR_EN for round-robin; otherwise fixed priority.
// Revision: 1.0 - initial release
// ============================================================================
module shiftreg_load_ctrl #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 4,
    parameter int SHIFT_CYCLES = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        load,
    output logic [DATA_W-1:0]           parallel_data_in,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        done,
    output logic [$clog2(NUM_REQ)-1:0]  done_id
);

    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] pdata_q, pdata_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [GW-1:0]     done_id_q;
    logic              load_q, busy_q, done_q;
    logic [GW-1:0]     w_win;
    logic              w_found;
    logic              w_accept;

`ifdef SHREG_CTRL_RR_EN
    logic [GW-1:0]     last_q, last_d;

    // Search begins one past the last winner so every requester gets a turn.
    always_comb begin
        int idx;
        idx     = 0;
        w_win   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(last_q) + 1 + i) % NUM_REQ;
            if (!w_found && req_valid[idx]) begin
                w_win   = GW'(idx);
                w_found = 1'b1;
            end
        end
    end
`else
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req_valid[i]) begin
                w_win   = GW'(i);
                w_found = 1'b1;
            end
        end
    end
`endif

    assign w_accept = reset && (state_q == S_IDLE) && w_found;

    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_win] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pdata_d = pdata_q;
        grant_d = grant_q;
`ifdef SHREG_CTRL_RR_EN
        last_d  = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (w_found) begin
                    state_d = S_LOAD;
                    pdata_d = req_data[int'(w_win)*DATA_W +: DATA_W];
                    grant_d = w_win;
`ifdef SHREG_CTRL_RR_EN
                    last_d  = w_win;
`endif
                end
            end
            S_LOAD: begin
                state_d = S_SHIFT;
                cnt_d   = 8'(SHIFT_CYCLES - 1);
            end
            S_SHIFT: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output flops are driven from next-state so they line up with the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            pdata_q   <= '0;
            grant_q   <= '0;
            done_id_q <= '0;
            load_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SHREG_CTRL_RR_EN
            last_q    <= GW'(NUM_REQ - 1);
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pdata_q <= pdata_d;
            grant_q <= grant_d;
            load_q  <= (state_d == S_LOAD);
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_SHIFT) && (cnt_d == 8'd0);
            if ((state_d == S_SHIFT) && (cnt_d == 8'd0)) begin
                done_id_q <= grant_d;
            end
`ifdef SHREG_CTRL_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    assign load             = load_q;
    assign parallel_data_in = pdata_q;
    assign busy             = busy_q;
    assign grant_id         = grant_q;
    assign done             = done_q;
    assign done_id          = done_id_q;

endmodule
`default_nettype wire

// File: tb/tb_shiftreg_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_shiftreg_load_ctrl
// Purpose : Directed self-checking bench for shiftreg_load_ctrl (SHIFT_CYCLES
//           4 and 1 instances). Follows SHREG_CTRL_RR_EN for grant order.
// Revision: 1.0 - initial release
// ============================================================================
module tb_shiftreg_load_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  rv = '0, rv1 = '0;
    logic [15:0] rd = '0, rd1 = '0;
    logic [3:0]  ready, ready1;
    logic        load, load1, busy, busy1, done, done1;
    logic [3:0]  pdata, pdata1;
    logic [1:0]  gid, gid1, did, did1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    shiftreg_load_ctrl #(.NUM_REQ(4), .DATA_W(4), .SHIFT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .req_valid(rv), .req_data(rd),
        .req_ready(ready), .load(load), .parallel_data_in(pdata),
        .busy(busy), .grant_id(gid), .done(done), .done_id(did)
    );

    shiftreg_load_ctrl #(.NUM_REQ(4), .DATA_W(4), .SHIFT_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(rv1), .req_data(rd1),
        .req_ready(ready1), .load(load1), .parallel_data_in(pdata1),
        .busy(busy1), .grant_id(gid1), .done(done1), .done_id(did1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at the falling edge, then settle before checking.
    task automatic cyc(input logic [3:0] v, input logic [15:0] d);
        @(negedge clk);
        rv = v;
        rd = d;
        #1;
    endtask

    task automatic cyc1(input logic [3:0] v, input logic [15:0] d);
        @(negedge clk);
        rv1 = v;
        rd1 = d;
        #1;
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        reset = 1'b0;
        rv    = '0;
        #1;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int e;
        // Reset values
        @(negedge clk);
        #1;
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_load",  32'(load),  32'h0);
        chk("rst_pdata", 32'(pdata), 32'h0);
        chk("rst_busy",  32'(busy),  32'h0);
        chk("rst_gid",   32'(gid),   32'h0);
        chk("rst_done",  32'(done),  32'h0);
        chk("rst_did",   32'(did),   32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Single request from requester 2
        cyc(4'b0100, 16'h0A00);
        chk("t1_ready_T", 32'(ready), 32'h4);
        chk("t1_busy_T",  32'(busy),  32'h0);
        cyc(4'b0000, 16'h0A00);
        chk("t1_load",  32'(load),  32'h1);
        chk("t1_pdata", 32'(pdata), 32'hA);
        chk("t1_gid",   32'(gid),   32'h2);
        chk("t1_busy1", 32'(busy),  32'h1);
        chk("t1_ready_load", 32'(ready), 32'h0);
        for (int j = 0; j < 3; j++) begin
            cyc(4'b0000, 16'h0A00);
            chk("t1_busy_sh", 32'(busy), 32'h1);
            chk("t1_done_early", 32'(done), 32'h0);
            chk("t1_load_sh", 32'(load), 32'h0);
        end
        cyc(4'b0000, 16'h0A00);
        chk("t1_done", 32'(done), 32'h1);
        chk("t1_did",  32'(did),  32'h2);
        chk("t1_busy5", 32'(busy), 32'h1);
        cyc(4'b0000, 16'h0A00);
        chk("t1_idle_busy", 32'(busy), 32'h0);
        chk("t1_idle_done", 32'(done), 32'h0);

        // All four requesters continuously valid
        rst_pulse();
        for (int k = 0; k < 5; k++) begin
`ifdef SHREG_CTRL_RR_EN
            e = k % 4;
`else
            e = 0;
`endif
            cyc(4'b1111, 16'h4321);
            chk("t2_ready", 32'(ready), 32'(4'(1 << e)));
            chk("t2_noload", 32'(load), 32'h0);
            cyc(4'b1111, 16'h4321);
            chk("t2_load",  32'(load),  32'h1);
            chk("t2_pdata", 32'(pdata), 32'(e + 1));
            chk("t2_gid",   32'(gid),   32'(e));
            for (int j = 0; j < 4; j++) begin
                cyc(4'b1111, 16'h4321);
                chk("t2_gap_load",  32'(load),  32'h0);
                chk("t2_gap_ready", 32'(ready), 32'h0);
                chk("t2_done", 32'(done), 32'(j == 3));
                if (j == 3) chk("t2_did", 32'(did), 32'(e));
            end
        end
        cyc(4'b0000, 16'h0000);

        // Requester 1 arrives during requester 0's shift window
        rst_pulse();
        cyc(4'b0001, 16'h00B5);
        chk("t3_ready0", 32'(ready), 32'h1);
        cyc(4'b0000, 16'h00B5);
        chk("t3_load0",  32'(load),  32'h1);
        chk("t3_pdata0", 32'(pdata), 32'h5);
        for (int j = 0; j < 4; j++) begin
            cyc(4'b0010, 16'h00B5);
            chk("t3_wait_ready", 32'(ready), 32'h0);
            chk("t3_wait_load",  32'(load),  32'h0);
            chk("t3_wait_busy",  32'(busy),  32'h1);
        end
        chk("t3_done0", 32'(done), 32'h1);
        chk("t3_did0",  32'(did),  32'h0);
        cyc(4'b0010, 16'h00B5);
        chk("t3_ready1", 32'(ready), 32'h2);
        chk("t3_idle_load", 32'(load), 32'h0);
        cyc(4'b0000, 16'h00B5);
        chk("t3_load1",  32'(load),  32'h1);
        chk("t3_pdata1", 32'(pdata), 32'hB);
        chk("t3_gid1",   32'(gid),   32'h1);
        for (int j = 0; j < 4; j++) begin
            cyc(4'b0000, 16'h00B5);
            chk("t3_done1", 32'(done), 32'(j == 3));
        end
        chk("t3_did1", 32'(did), 32'h1);

        // Reset in the second shift cycle of a requester-3 transaction
        cyc(4'b1000, 16'hC000);
        chk("t4_ready", 32'(ready), 32'h8);
        cyc(4'b0000, 16'hC000);
        chk("t4_load", 32'(load), 32'h1);
        cyc(4'b0000, 16'hC000);
        @(negedge clk);
        reset = 1'b0;
        rv    = 4'b1000;
        rd    = 16'hC000;
        #1;
        chk("t4_r_load",  32'(load),  32'h0);
        chk("t4_r_busy",  32'(busy),  32'h0);
        chk("t4_r_done",  32'(done),  32'h0);
        chk("t4_r_pdata", 32'(pdata), 32'h0);
        chk("t4_r_gid",   32'(gid),   32'h0);
        chk("t4_r_did",   32'(did),   32'h0);
        chk("t4_r_ready", 32'(ready), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t4_rel_ready", 32'(ready), 32'h8);
        chk("t4_rel_busy",  32'(busy),  32'h0);
        cyc(4'b0000, 16'hC000);
        chk("t4_load3",  32'(load),  32'h1);
        chk("t4_pdata3", 32'(pdata), 32'hC);
        chk("t4_gid3",   32'(gid),   32'h3);
        chk("t4_nodone", 32'(done),  32'h0);
        for (int j = 0; j < 4; j++) begin
            cyc(4'b0000, 16'hC000);
            chk("t4_done3", 32'(done), 32'(j == 3));
        end
        chk("t4_did3", 32'(did), 32'h3);

        // Twenty idle cycles
        for (int j = 0; j < 20; j++) begin
            cyc(4'b0000, 16'hFFFF);
            chk("t6_load",  32'(load),  32'h0);
            chk("t6_busy",  32'(busy),  32'h0);
            chk("t6_done",  32'(done),  32'h0);
            chk("t6_ready", 32'(ready), 32'h0);
            chk("t6_pdata", 32'(pdata), 32'hC);
        end

        // SHIFT_CYCLES = 1, requester 0 held valid: loads 3 cycles apart
        for (int k = 0; k < 2; k++) begin
            cyc1(4'b0001, 16'h0007);
            chk("t5_ready", 32'(ready1), 32'h1);
            chk("t5_noload", 32'(load1), 32'h0);
            cyc1(4'b0001, 16'h0007);
            chk("t5_load",  32'(load1),  32'h1);
            chk("t5_pdata", 32'(pdata1), 32'h7);
            chk("t5_early_done", 32'(done1), 32'h0);
            cyc1(4'b0001, 16'h0007);
            chk("t5_done",  32'(done1),  32'h1);
            chk("t5_did",   32'(did1),   32'h0);
            chk("t5_load_off", 32'(load1), 32'h0);
            chk("t5_ready_off", 32'(ready1), 32'h0);
        end
        cyc1(4'b0000, 16'h0007);
        chk("t5_idle_busy", 32'(busy1), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
